// File: rtl/dut_initiator.sv
// Bus initiator for the OR-combiner: writes operands A and B, polls status, reads the result
// and returns it (or a timeout) on a valid/ready response port.
module dut_initiator #(
    parameter logic [2:0]  A_ADDR      = 3'd0,
    parameter logic [2:0]  B_ADDR      = 3'd5,
    parameter logic [2:0]  STATUS_ADDR = 3'd2,
    parameter logic [2:0]  RESULT_ADDR = 3'd3,
    parameter int unsigned POLL_LIMIT  = 600
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_timeout,
    output logic [2:0] write_address,
    output logic [7:0] write_data,
    output logic       write_en,
    input  logic       write_rdy,
    output logic [2:0] read_address,
    output logic       read_en,
    input  logic [7:0] read_data,
    input  logic       read_rdy,
    output logic [7:0] txn_count,
    output logic [7:0] timeout_count
);

    typedef enum logic [2:0] {
        StIdle,
        StWrA,
        StWrB,
        StPoll,
        StRdY,
        StResp
    } state_e;

    localparam logic [9:0] PollLast = 10'(POLL_LIMIT - 1);

    state_e     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] result_q, result_d;
    logic       timeout_q, timeout_d;
    logic [9:0] poll_cnt_q, poll_cnt_d;
    logic [7:0] txn_q, txn_d;
    logic [7:0] tmo_q, tmo_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            timeout_q  <= 1'b0;
            poll_cnt_q <= '0;
            txn_q      <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            result_q   <= result_d;
            timeout_q  <= timeout_d;
            poll_cnt_q <= poll_cnt_d;
            txn_q      <= txn_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        timeout_d  = timeout_q;
        poll_cnt_d = poll_cnt_q;
        txn_d      = txn_q;
        tmo_d      = tmo_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    state_d = StWrA;
                end
            end
            StWrA: begin
                if (write_rdy) state_d = StWrB;
            end
            StWrB: begin
                if (write_rdy) begin
                    poll_cnt_d = '0;
                    state_d    = StPoll;
                end
            end
            StPoll: begin
                if (read_rdy) begin
                    if (read_data[0]) begin
                        state_d = StRdY;
                    end else if (poll_cnt_q == PollLast) begin
                        timeout_d = 1'b1;
                        result_d  = '0;
                        state_d   = StResp;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 10'd1;
                    end
                end
            end
            StRdY: begin
                if (read_rdy) begin
                    result_d  = read_data;
                    timeout_d = 1'b0;
                    state_d   = StResp;
                end
            end
            StResp: begin
                if (res_ready) begin
                    txn_d = txn_q + 8'd1;
                    // Timeout counter saturates rather than wrapping.
                    if (timeout_q && (tmo_q != 8'hFF)) tmo_d = tmo_q + 8'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs depend on state and registers only; RST gating cmd_ready is the one exception.
    always_comb begin
        cmd_ready     = (state_q == StIdle) && !RST;
        write_en      = 1'b0;
        write_address = '0;
        write_data    = '0;
        read_en       = 1'b0;
        read_address  = '0;
        res_valid     = (state_q == StResp);
        res_data      = result_q;
        res_timeout   = timeout_q;
        unique case (state_q)
            StWrA: begin
                write_en      = 1'b1;
                write_address = A_ADDR;
                write_data    = a_q;
            end
            StWrB: begin
                write_en      = 1'b1;
                write_address = B_ADDR;
                write_data    = b_q;
            end
            StPoll: begin
                read_en      = 1'b1;
                read_address = STATUS_ADDR;
            end
            StRdY: begin
                read_en      = 1'b1;
                read_address = RESULT_ADDR;
            end
            default: ;
        endcase
    end

    assign txn_count     = txn_q;
    assign timeout_count = tmo_q;

endmodule

// File: tb/tb_dut_initiator.sv
// Self-checking bench for dut_initiator: target model with delayed status, scoreboards for
// writes and responses, backpressure, mid-command reset and counter wrap/saturation.
module tb_dut_initiator;

    localparam logic [2:0]  AAddr      = 3'd0;
    localparam logic [2:0]  BAddr      = 3'd5;
    localparam logic [2:0]  StatusAddr = 3'd2;
    localparam logic [2:0]  ResultAddr = 3'd3;
    localparam int unsigned PollLimit  = 40;
    localparam int          Never      = 1 << 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [7:0] cmd_a, cmd_b;
    logic       res_valid, res_timeout;
    logic       res_ready = 1'b1;
    logic [7:0] res_data;
    logic [2:0] write_address, read_address;
    logic [7:0] write_data, read_data;
    logic       write_en, read_en;
    logic       write_rdy = 1'b1;
    logic       read_rdy  = 1'b1;
    logic [7:0] txn_count, timeout_count;

    dut_initiator #(
        .A_ADDR      (AAddr),
        .B_ADDR      (BAddr),
        .STATUS_ADDR (StatusAddr),
        .RESULT_ADDR (ResultAddr),
        .POLL_LIMIT  (PollLimit)
    ) u_dut (
        .CLK           (clk),
        .RST           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_a         (cmd_a),
        .cmd_b         (cmd_b),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_timeout   (res_timeout),
        .write_address (write_address),
        .write_data    (write_data),
        .write_en      (write_en),
        .write_rdy     (write_rdy),
        .read_address  (read_address),
        .read_en       (read_en),
        .read_data     (read_data),
        .read_rdy      (read_rdy),
        .txn_count     (txn_count),
        .timeout_count (timeout_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Target model: status goes high after status_delay reads of the current command.
    int         status_delay = 0;
    int         stat_cmd     = 0;
    int         stat_reads   = 0;
    int         res_reads    = 0;
    logic [7:0] last_a = '0, last_b = '0;

    assign read_data = (read_address == StatusAddr) ? {7'd0, (stat_cmd >= status_delay)} :
                       (read_address == ResultAddr) ? (last_a | last_b) : 8'hA5;

    always @(posedge clk) begin
        if (!rst && read_en && read_rdy) begin
            if (read_address == StatusAddr) begin
                stat_reads <= stat_reads + 1;
                stat_cmd   <= stat_cmd + 1;
            end else if (read_address == ResultAddr) begin
                res_reads <= res_reads + 1;
            end
        end
        if (!rst && write_en && write_rdy) begin
            if (write_address == AAddr) begin
                last_a   <= write_data;
                stat_cmd <= 0;
            end else begin
                last_b <= write_data;
            end
        end
    end

    // Backpressure driver: each stall counter holds its rdy low for that many request cycles.
    int wr_stall = 0, rd_stall = 0, rs_stall = 0;

    always @(posedge clk) begin
        #1;
        if (write_en && wr_stall > 0) begin
            write_rdy = 1'b0;
            wr_stall--;
        end else write_rdy = 1'b1;
        if (read_en && read_address == ResultAddr && rd_stall > 0) begin
            read_rdy = 1'b0;
            rd_stall--;
        end else read_rdy = 1'b1;
        if (res_valid && rs_stall > 0) begin
            res_ready = 1'b0;
            rs_stall--;
        end else res_ready = 1'b1;
    end

    // Scoreboards and bus monitor; sampled on the falling edge, between input updates.
    logic [10:0] wr_q[$];
    logic [8:0]  rsp_q[$];
    int          resp_cnt = 0;
    logic [7:0]  exp_txn  = '0, exp_tmo = '0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_snap  = '0;
    logic [31:0] snap;

    always @(negedge clk) begin
        snap = {write_en, write_address, write_data, read_en, read_address,
                res_valid, res_data, res_timeout, 6'd0};
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            chk("excl_en", {31'd0, write_en & read_en}, 0);
            if (!write_en) chk("wr_idle", {21'd0, write_address, write_data}, 0);
            if (!read_en) chk("rd_idle", {29'd0, read_address}, 0);
            if (prev_stall) chk("stable", snap, prev_snap);
            if (write_en && write_rdy) begin
                if (wr_q.size() == 0) chk("wr_extra", 1, 0);
                else begin
                    logic [10:0] e;
                    e = wr_q.pop_front();
                    chk("wr_addr", {29'd0, write_address}, {29'd0, e[10:8]});
                    chk("wr_data", {24'd0, write_data}, {24'd0, e[7:0]});
                end
            end
            if (res_valid && res_ready) begin
                if (rsp_q.size() == 0) chk("rsp_extra", 1, 0);
                else begin
                    logic [8:0] e;
                    e = rsp_q.pop_front();
                    chk("res_timeout", {31'd0, res_timeout}, {31'd0, e[8]});
                    chk("res_data", {24'd0, res_data}, {24'd0, e[7:0]});
                end
                resp_cnt++;
                exp_txn = exp_txn + 8'd1;
                if (res_timeout && exp_tmo != 8'hFF) exp_tmo = exp_tmo + 8'd1;
            end
            prev_stall = (write_en && !write_rdy) || (read_en && !read_rdy) ||
                         (res_valid && !res_ready);
        end
        prev_snap = snap;
    end

    int last_lat;

    task automatic start_cmd(input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("cmd_ready_wait", {31'd0, cmd_ready}, 1);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        tick();
        cmd_valid = 1'b0;
        cmd_a     = 8'($urandom);
        cmd_b     = 8'($urandom);
    endtask

    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input int delay,
                           input bit exp_to);
        int sr0, rr0, rc0, n;
        sr0 = stat_reads;
        rr0 = res_reads;
        rc0 = resp_cnt;
        status_delay = delay;
        wr_q.push_back({AAddr, a});
        wr_q.push_back({BAddr, b});
        rsp_q.push_back({exp_to, exp_to ? 8'h00 : (a | b)});
        start_cmd(a, b);
        last_lat = 0;
        while (!res_valid && last_lat < 3000) begin
            tick();
            last_lat++;
        end
        n = 0;
        while (resp_cnt == rc0 && n < 100) begin
            tick();
            n++;
        end
        chk("resp_seen", resp_cnt - rc0, 1);
        chk("status_reads", stat_reads - sr0, exp_to ? PollLimit : delay + 1);
        chk("result_reads", res_reads - rr0, exp_to ? 0 : 1);
        chk("txn_count", {24'd0, txn_count}, {24'd0, exp_txn});
        chk("timeout_count", {24'd0, timeout_count}, {24'd0, exp_tmo});
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        exp_txn = '0;
        exp_tmo = '0;
        rsp_q.delete();
        wr_q.delete();
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 0);
        chk("rst_outputs", {write_en, read_en, res_valid, res_timeout, res_data,
                            write_data, write_address, read_address}, 0);
        chk("rst_counts", {16'd0, txn_count, timeout_count}, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("idle_cmd_ready", {31'd0, cmd_ready}, 1);

        // Happy path: result ready on first poll.
        run_cmd(8'h0F, 8'hF0, 0, 1'b0);
        chk("latency", last_lat, 4);
        chk("txn_one", {24'd0, txn_count}, 1);

        // Status low for 37 polls.
        run_cmd(8'h30, 8'h0C, 37, 1'b0);

        // Status never set.
        run_cmd(8'h12, 8'h34, Never, 1'b1);
        chk("tmo_one", {24'd0, timeout_count}, 1);

        // Backpressure on writes, result read and response.
        wr_stall = 3;
        rd_stall = 2;
        rs_stall = 5;
        run_cmd(8'hA0, 8'h05, 2, 1'b0);
        chk("stalls_used", wr_stall + rd_stall + rs_stall, 0);

        // Reset in the middle of polling.
        status_delay = Never;
        wr_q.push_back({AAddr, 8'h55});
        wr_q.push_back({BAddr, 8'h22});
        start_cmd(8'h55, 8'h22);
        n = 0;
        while (!(read_en && read_address == StatusAddr) && n < 20) begin
            tick();
            n++;
        end
        chk("reached_poll", {31'd0, read_en}, 1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_en", {30'd0, write_en, read_en}, 0);
        chk("midrst_cmd_ready", {31'd0, cmd_ready}, 0);
        chk("midrst_counts", {16'd0, txn_count, timeout_count}, 0);
        chk("midrst_wr_done", wr_q.size(), 0);
        tick();
        rst = 1'b0;
        #1;
        exp_txn = '0;
        exp_tmo = '0;
        rsp_q.delete();
        chk("post_rst_ready", {31'd0, cmd_ready}, 1);
        chk("post_rst_txn", {24'd0, txn_count}, 0);
        run_cmd(8'h81, 8'h18, 3, 1'b0);

        // txn_count wraps after 256 commands.
        pulse_reset();
        for (int i = 0; i < 256; i++) begin
            run_cmd(8'(i), 8'(~i), i % 3, 1'b0);
        end
        chk("txn_wrap", {24'd0, txn_count}, 0);

        // timeout_count saturates.
        for (int i = 0; i < 300; i++) begin
            run_cmd(8'(i * 7), 8'(i), Never, 1'b1);
        end
        chk("tmo_sat", {24'd0, timeout_count}, 255);
        chk("sb_empty", rsp_q.size() + wr_q.size(), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
